// File: rtl/seg_scan_if.sv
// seg_scan_if: bundles the load-side inputs and the scanned display outputs of seg_scan_ctrl.
// master: drives data/dp_in/blank/load and observes seg/dp/an/frame_start.
// slave:  the scan controller side.
interface seg_scan_if #(parameter int DIGITS = 4);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0] dp_in, blank, an;
  logic load, dp, frame_start;
  logic [6:0] seg;
  modport master(output data, dp_in, blank, load, input seg, dp, an, frame_start);
  modport slave(input data, dp_in, blank, load, output seg, dp, an, frame_start);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan controller with double-buffered digit data.
// Ports: clk, rst_n (async active-low), bus (seg_scan_if.slave):
//   data/dp_in/blank/load in; seg {g..a}, dp, an, frame_start out (all registered).
// Optional: define SEG_SCAN_LEADZERO_EN to blank digits above the highest nonzero nibble.
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst_n,
  seg_scan_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
  localparam logic [6:0] SI = {7{ACTIVE_LOW != 0}};
  localparam logic [DIGITS-1:0] AI = {DIGITS{ACTIVE_LOW != 0}};
  localparam logic [6:0] GLYPH [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                        7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic tc, wrap, wrap_q;
  logic [DIGITS-1:0][3:0] pend_data, act_data;
  logic [DIGITS-1:0] pend_dp, pend_blank, act_dp, act_blank, dark, an_n;
  logic [6:0] seg_n;
  logic dp_n;
`ifdef SEG_SCAN_LEADZERO_EN
  logic zr;
`endif
  assign tc = presc == P_LAST;
  assign wrap = tc && idx == I_LAST;
  always_comb begin
    dark = act_blank;
`ifdef SEG_SCAN_LEADZERO_EN
    zr = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zr = zr & (act_data[i] == 4'h0);
      dark[i] = dark[i] | zr;
    end
`endif
    seg_n = dark[idx] ? 7'h00 : GLYPH[act_data[idx]];
    dp_n = act_dp[idx] & ~dark[idx];
    an_n = presc < P_BLANK ? '0 : DIGITS'(1) << idx;
  end
  // Outputs are registered from the pre-edge counter state, giving the one-clock lag.
  // wrap_q delays frame_start so it lines up with digit 0's first blanked output cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      presc <= '0;
      idx <= '0;
      wrap_q <= 1'b0;
      pend_data <= '0;
      pend_dp <= '0;
      pend_blank <= '0;
      act_data <= '0;
      act_dp <= '0;
      act_blank <= '0;
      bus.seg <= SI;
      bus.dp <= SI[0];
      bus.an <= AI;
      bus.frame_start <= 1'b0;
    end else begin
      presc <= tc ? '0 : presc + 1'b1;
      if (tc) idx <= wrap ? '0 : idx + 1'b1;
      if (bus.load) {pend_data, pend_dp, pend_blank} <= {bus.data, bus.dp_in, bus.blank};
      if (wrap) {act_data, act_dp, act_blank} <= bus.load ? {bus.data, bus.dp_in, bus.blank}
                                                          : {pend_data, pend_dp, pend_blank};
      wrap_q <= wrap;
      bus.frame_start <= wrap_q;
      bus.seg <= seg_n ^ SI;
      bus.dp <= dp_n ^ SI[0];
      bus.an <= an_n ^ AI;
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized scoreboard bench for seg_scan_ctrl against a frame-level model.
module tb_seg_scan_ctrl;
  localparam int D = 4, RD = 8, BC = 2, FR = RD * D;
  typedef struct packed {
    logic [6:0] seg;
    logic dp;
    logic [3:0] an;
    logic fs;
  } obs_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int tests = 0, fails = 0, n = 0;
  obs_t exp_q [$];
  logic [6:0] glyph [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                             7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
  logic [15:0] p_data, a_data;
  logic [3:0] p_dp, p_bl, a_dp, a_bl;
  seg_scan_if #(.DIGITS(D)) bus ();
  seg_scan_ctrl #(.DIGITS(D), .REFRESH_DIV(RD), .BLANK_CYC(BC), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    n = 0;
    {p_data, p_dp, p_bl, a_data, a_dp, a_bl} = '0;
  endtask
  // n counts clock edges since reset release; slot and digit follow from plain arithmetic.
  task automatic model_step();
    int presc = n % RD;
    int idx = (n / RD) % D;
    logic dark;
    obs_t e;
    dark = a_bl[idx];
`ifdef SEG_SCAN_LEADZERO_EN
    begin
      int top = 0;
      for (int i = 0; i < D; i++) if (a_data[4*i +: 4] != 4'h0) top = i;
      dark = dark | (idx > top);
    end
`endif
    e.seg = dark ? 7'h7f : ~glyph[a_data[4*idx +: 4]];
    e.dp = ~(a_dp[idx] & ~dark);
    e.an = presc < BC ? 4'hf : ~(4'b0001 << idx);
    e.fs = n > 0 && n % FR == 0;
    exp_q.push_back(e);
    if (bus.load) {p_data, p_dp, p_bl} = {bus.data, bus.dp_in, bus.blank};
    if (n % FR == FR - 1) {a_data, a_dp, a_bl} = {p_data, p_dp, p_bl};
    n++;
  endtask
  task automatic cycle(input logic ld);
    bus.load = ld;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask
  task automatic load_cycle(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    bus.data = d;
    bus.dp_in = p;
    bus.blank = b;
    cycle(1'b1);
  endtask
  task automatic run(input int k);
    repeat (k) cycle(1'b0);
  endtask
  task automatic run_to(input int m);
    int guard = 0;
    while (n % FR != m && guard < 2 * FR) begin
      cycle(1'b0);
      guard++;
    end
  endtask
  task automatic check_idle(input string tag);
    tests++;
    if ({bus.seg, bus.dp, bus.an, bus.frame_start} !== {7'h7f, 1'b1, 4'hf, 1'b0}) begin
      fails++;
      $display("FAIL %s got seg=%b dp=%b an=%b fs=%b want seg=1111111 dp=1 an=1111 fs=0",
               tag, bus.seg, bus.dp, bus.an, bus.frame_start);
    end
  endtask
  initial forever begin
    obs_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if ({bus.seg, bus.dp, bus.an, bus.frame_start} !== e) begin
        fails++;
        $display("FAIL scan t=%0t got seg=%b dp=%b an=%b fs=%b want seg=%b dp=%b an=%b fs=%b",
                 $time, bus.seg, bus.dp, bus.an, bus.frame_start, e.seg, e.dp, e.an, e.fs);
      end
    end
  end
  initial begin
    bus.data = '0;
    bus.dp_in = '0;
    bus.blank = '0;
    bus.load = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_idle("reset_hold");
    rst_n = 1'b1;
    run(2 * FR);
    run_to(10);
    load_cycle(16'h12a8, 4'b0000, 4'b0000);
    run(2 * FR + 16);
    run_to(3);
    load_cycle(16'h0001, 4'b0000, 4'b0000);
    run_to(20);
    load_cycle(16'h0002, 4'b0000, 4'b0000);
    run(2 * FR);
    run_to(FR - 1);
    load_cycle(16'h5f3c, 4'b1010, 4'b0000);
    run(FR + 8);
    run_to(0);
    load_cycle(16'h4321, 4'b0100, 4'b0100);
    run(2 * FR + 8);
    load_cycle(16'h0070, 4'b0000, 4'b0000);
    run(2 * FR + 8);
    repeat (40) begin
      run($urandom_range(1, 40));
      load_cycle(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & 5'd7));
    end
    run(FR + 4);
    run_to(2);
    load_cycle(16'hbeef, 4'b1111, 4'b0000);
    run_to(18);
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset");
    model_reset();
    @(negedge clk);
    check_idle("reset_clocked");
    @(negedge clk);
    rst_n = 1'b1;
    run(2 * FR + 6);
    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed 7-segment digits, legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000: clock cycles per digit slot, legal range 4..2^20.
REQ-003 Parameter BLANK_CYC, default 1000: leading cycles of each slot with all anodes off, legal range 1..REFRESH_DIV-2.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 means seg, dp and an are driven active-low; 0 means active-high.
REQ-005 clk  input  1: single clock; all state on rising edge.
REQ-006 rst_n  input  1: reset; the block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 data  input  4*DIGITS: hex nibble per digit; digit i uses data[4i+3:4i].
REQ-008 dp_in  input  DIGITS: decimal-point request per digit.
REQ-009 blank  input  DIGITS: force digit i dark when bit i is 1.
REQ-010 load  input  1: one-cycle strobe; captures data, dp_in and blank into the pending register.
REQ-011 seg  output  7: segments {g,f,e,d,c,b,a}, registered.
REQ-012 dp  output  1: decimal point, registered.
REQ-013 an  output  DIGITS: digit enables, one-hot-active or all inactive, registered.
REQ-014 frame_start  output  1: one-cycle pulse when the slot index wraps to digit 0.

Function
REQ-015 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; at terminal count, the slot index SHALL advance, wrapping DIGITS-1 -> 0.
REQ-016 When prescaler < BLANK_CYC, all anodes SHALL be inactive (ghost suppression); otherwise only an[idx] SHALL be active.
REQ-017 load=1 SHALL overwrite the pending register in the same cycle; repeated loads within a frame keep the last one.
REQ-018 The pending register SHALL be copied to the active register on the cycle the index wraps to 0; if load coincides with the wrap, the newly loaded value SHALL take effect for the new frame.
REQ-019 frame_start SHALL assert for exactly the cycle after the index wrap, coincident with the first blanked cycle of digit 0.
REQ-020 Hex decode (active-high {g..a}): 0=0111111, 1=0000110, 8=1111111, A=1110111, F=1110001; the full 0-F table follows standard 7-segment glyphs.
REQ-021 A digit with blank=1 SHALL drive seg and dp inactive, while its anode timing is unchanged.
REQ-022 seg, dp and an SHALL lag the internal prescaler and index state by exactly one clock.
REQ-023 With ACTIVE_LOW=1, every output bit of seg, dp and an SHALL be the inverse of its active-high value.
REQ-024 With DIGITS=1, the index SHALL stay at 0 and frame_start SHALL pulse every REFRESH_DIV cycles.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately clear the prescaler, index, pending and active registers to 0 and drive seg, dp and an inactive, without waiting for a clock.
REQ-026 Under reset, frame_start SHALL be 0.
REQ-027 After rst_n deasserts, the first digit-0 slot SHALL begin at the first clock edge, and frame_start SHALL not pulse until the first wrap.
REQ-028 Reset mid-frame SHALL discard any pending load.

Configuration
REQ-029 Macro SEG_SCAN_LEADZERO_EN SHALL control leading-zero suppression.
REQ-030 When SEG_SCAN_LEADZERO_EN is defined, digits above the highest nonzero active nibble SHALL be blanked (seg and dp inactive), and digit 0 SHALL always be shown.
REQ-031 When SEG_SCAN_LEADZERO_EN is undefined, all non-blank digits SHALL display, including leading zeros, and no suppression logic SHALL be present.

Verification (DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2, ACTIVE_LOW=1)
REQ-032 Free-run a frame -> the an sequence per 8-cycle slot is 1111,1111,1110x6, then 1111,1111,1101x6, and so on; frame_start pulses every 32 cycles.
REQ-033 Load data=16'h12A8 mid-frame -> the display is unchanged until the wrap; the next frame shows seg=0000000 on digit 0 (8) and 0001000 on digit 1 (A).
REQ-034 Load 16'h0001, then 16'h0002 in the same frame -> only 16'h0002 is displayed; load on the exact wrap cycle -> displayed in the new frame.
REQ-035 Drop rst_n low in digit 2 -> seg=1111111, dp=1 and an=1111 with no clock edge; after release, digit 0 is scanned first.
REQ-036 blank=4'b0100 and dp_in=4'b0100 -> digit 2 anode cycles but seg=1111111 and dp=1.
REQ-037 With SEG_SCAN_LEADZERO_EN, data=16'h0070 -> digits 3 and 2 are dark, and digits 1 and 0 show 7 and 0; without the macro, all four digits show.
